pow_sequencer: RTL and testbench

//   Sequences a shared single-cycle WIDTH x WIDTH multiplier to compute base**exp,

---
 rtl/pow_sequencer.sv | 111 +++++++++++
 tb/tb_pow_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pow_sequencer.sv
// pow_sequencer: computes base**exp mod 2^WIDTH by stepping one shared
// WIDTH x WIDTH multiplier once per clock, with a sticky overflow flag.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, only sampled while idle
//   base, exp       operands, latched when a request is accepted
//   busy            high while multiplying and in the completion cycle
//   done            one-cycle completion pulse
//   result          base**exp mod 2^WIDTH, held until the next completion
//   ovf             set if any intermediate product exceeded WIDTH bits
module pow_sequencer #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned EXP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] base_l;
  logic [WIDTH-1:0] acc;
  logic [EXP_W-1:0] cnt;
  logic             ovf_i;

  logic [PW-1:0]    prod_c;
  logic             prod_ovf_c;
  logic             ovf_next_c;

  // Full-width product; any bit above WIDTH means the truncated value lost data.
  assign prod_c     = PW'(acc) * PW'(base_l);
  assign prod_ovf_c = |prod_c[PW-1:WIDTH];
  assign ovf_next_c = ovf_i | prod_ovf_c;

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      base_l <= '0;
      acc    <= '0;
      cnt    <= '0;
      ovf_i  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_l <= base;
            cnt    <= exp;
            acc    <= WIDTH'(1);
            ovf_i  <= 1'b0;
            busy   <= 1'b1;
            if (exp == '0) begin
              // x**0 completes straight away with result 1.
              state  <= S_DONE;
              done   <= 1'b1;
              result <= WIDTH'(1);
              ovf    <= 1'b0;
            end else begin
              state <= S_MUL;
            end
          end
        end

        S_MUL: begin
          acc   <= prod_c[WIDTH-1:0];
          ovf_i <= ovf_next_c;
          cnt   <= cnt - EXP_W'(1);
          if (cnt == EXP_W'(1)) begin
            // Last multiply: publish the product directly on DONE entry.
            state  <= S_DONE;
            done   <= 1'b1;
            result <= prod_c[WIDTH-1:0];
            ovf    <= ovf_next_c;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pow_sequencer.sv
// Directed bench for pow_sequencer: cycle-exact busy/done checks plus
// result/ovf values for hand-computed powers mod 64.
module tb_pow_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] tb_base;
  logic [3:0] tb_exp;
  logic       busy;
  logic       done;
  logic [5:0] result;
  logic       ovf;

  int tests_run;
  int tests_failed;
  logic [5:0] last_result;
  logic       last_ovf;

  pow_sequencer #(.WIDTH(6), .EXP_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (tb_base),
    .exp    (tb_exp),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue one request from IDLE and follow it cycle by cycle to IDLE again.
  // inject_at >= 0 pulses a conflicting request during that MUL cycle.
  task automatic run_op(input string tag, input logic [5:0] b, input logic [3:0] e,
                        input logic [5:0] r, input logic o, input int inject_at);
    start   = 1'b1;
    tb_base = b;
    tb_exp  = e;
    tick();
    start = 1'b0;
    for (int j = 0; j < int'(e); j++) begin
      check({tag, ":mul_busy"}, 32'(busy), 32'd1);
      check({tag, ":mul_done"}, 32'(done), 32'd0);
      check({tag, ":mul_result_hold"}, 32'(result), 32'(last_result));
      check({tag, ":mul_ovf_hold"}, 32'(ovf), 32'(last_ovf));
      if (j == inject_at) begin
        start   = 1'b1;
        tb_base = 6'd5;
        tb_exp  = 4'd1;
      end
      tick();
      start = 1'b0;
    end
    check({tag, ":done_pulse"}, 32'(done), 32'd1);
    check({tag, ":done_busy"}, 32'(busy), 32'd1);
    check({tag, ":result"}, 32'(result), 32'(r));
    check({tag, ":ovf"}, 32'(ovf), 32'(o));
    tick();
    check({tag, ":idle_done"}, 32'(done), 32'd0);
    check({tag, ":idle_busy"}, 32'(busy), 32'd0);
    check({tag, ":idle_result"}, 32'(result), 32'(r));
    check({tag, ":idle_ovf"}, 32'(ovf), 32'(o));
    last_result = r;
    last_ovf    = o;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_result  = 6'd0;
    last_ovf     = 1'b0;
    rst_n   = 1'b0;
    start   = 1'b0;
    tb_base = 6'd0;
    tb_exp  = 4'd0;

    // Reset state
    tick();
    tick();
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:result", 32'(result), 32'd0);
    check("rst:ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle:busy", 32'(busy), 32'd0);
    check("idle:done", 32'(done), 32'd0);

    // T1..T4
    run_op("t1_9e0", 6'd9, 4'd0, 6'd1, 1'b0, -1);
    run_op("t2_9e1", 6'd9, 4'd1, 6'd9, 1'b0, -1);
    run_op("t3_9e2", 6'd9, 4'd2, 6'd17, 1'b1, -1);
    run_op("t4_2e5", 6'd2, 4'd5, 6'd32, 1'b0, -1);
    run_op("t4_2e6", 6'd2, 4'd6, 6'd0, 1'b1, -1);

    // T5: conflicting request mid-MUL ignored, back-to-back accept afterwards
    run_op("t5_3e4", 6'd3, 4'd4, 6'd17, 1'b1, 1);
    run_op("t5_next", 6'd5, 4'd1, 6'd5, 1'b0, -1);

    // Boundary operands
    run_op("b0_e3", 6'd0, 4'd3, 6'd0, 1'b0, -1);
    run_op("b1_e15", 6'd1, 4'd15, 6'd1, 1'b0, -1);
    run_op("b63_e15", 6'd63, 4'd15, 6'd63, 1'b1, -1);

    // T6: reset during third MUL cycle
    start   = 1'b1;
    tb_base = 6'd9;
    tb_exp  = 4'd15;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t6:mul3_busy", 32'(busy), 32'd1);
    check("t6:mul3_result_hold", 32'(result), 32'd63);
    rst_n = 1'b0;
    #1;
    check("t6:rst_busy", 32'(busy), 32'd0);
    check("t6:rst_done", 32'(done), 32'd0);
    check("t6:rst_result", 32'(result), 32'd0);
    check("t6:rst_ovf", 32'(ovf), 32'd0);
    tick();
    check("t6:rst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t6:post_busy", 32'(busy), 32'd0);
    check("t6:post_done", 32'(done), 32'd0);
    last_result = 6'd0;
    last_ovf    = 1'b0;
    run_op("t6_2e3", 6'd2, 4'd3, 6'd8, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
